// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, EX forwarding,
// data-memory wait freeze with timeout, and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic [1:0]       result_src_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             pc_src_e,
    input  logic             mem_req_m,
    input  logic             mem_ready_m,
    input  logic             cnt_clr,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              lw_stall;
    logic              freeze;

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            wcnt        <= wcnt_nxt;
            timeout_err <= (state_nxt == ERR);
        end
    end

    // Memory wait FSM: ERR is terminal until reset
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            RUN: begin
                if (mem_req_m && !mem_ready_m) begin
                    state_nxt = WAIT;
                    wcnt_nxt  = WCNT_W'(1);
                end
            end
            WAIT: begin
                if (mem_ready_m) begin
                    state_nxt = RUN;
                end else if (wcnt == WCNT_W'(MAX_WAIT)) begin
                    state_nxt = ERR;
                end else begin
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end
            end
            default: state_nxt = ERR;
        endcase
    end

    assign lw_stall = (result_src_e == 2'b01) && (rd_e != 5'd0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign freeze   = (state == WAIT) || (state == ERR) ||
                      ((state == RUN) && mem_req_m && !mem_ready_m);

    // Pipeline control; while in reset every register is cleared and nothing holds
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b1;
        flush_e     = 1'b1;
        flush_w     = 1'b1;
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (rst_n) begin
            if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs1_e))      forward_a_e = 2'b10;
            else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_e)) forward_a_e = 2'b01;
            if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs2_e))      forward_b_e = 2'b10;
            else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_e)) forward_b_e = 2'b01;
            if (freeze) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_d = 1'b0;
                flush_e = 1'b0;
                flush_w = 1'b1;
            end else begin
                stall_f = lw_stall;
                stall_d = lw_stall;
                flush_d = pc_src_e;
                flush_e = lw_stall || pc_src_e;
                flush_w = 1'b0;
            end
        end
    end

    // Saturating event counters; clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (cnt_clr)                                   stall_cnt <= '0;
            else if ((freeze || lw_stall) && stall_cnt != CNT_MAX)
                                                           stall_cnt <= stall_cnt + CNT_W'(1);
            if (cnt_clr)                                   flush_cnt <= '0;
            else if (pc_src_e && !freeze && flush_cnt != CNT_MAX)
                                                           flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a behavioural model of stalls,
// flushes, forwarding, memory wait/timeout and event counters.
module tb_hazard_ctrl;

    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int          CNT_TOP  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] result_src_e;
    logic reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready_m, cnt_clr;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, timeout_err;
    logic [1:0] forward_a_e, forward_b_e;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    // Model: an outstanding memory access, how long it has waited, and a dead (timed-out) flag
    bit pending, dead;
    int elapsed, m_stall, m_flush;

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .result_src_e(result_src_e),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m), .cnt_clr(cnt_clr),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .timeout_err(timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_src(input logic [4:0] rs);
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        rst_n = 1'b1;
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        result_src_e = 2'b00;
        {reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready_m, cnt_clr} = '0;
    endtask

    // Check outputs for the inputs currently driven, then advance the model one clock
    task automatic step();
        bit lw, frz;
        #1;
        if (!rst_n) begin
            check("rst_stall", {stall_f, stall_d, stall_e, stall_m}, 4'b0000);
            check("rst_flush", {flush_d, flush_e, flush_w}, 3'b111);
            check("rst_fwd", {forward_a_e, forward_b_e}, 4'b0000);
            check("rst_tmo", timeout_err, 1'b0);
            check("rst_cnt", {stall_cnt, flush_cnt}, '0);
            pending = 0; dead = 0; elapsed = 0; m_stall = 0; m_flush = 0;
            return;
        end
        lw  = (result_src_e == 2'b01) && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        frz = dead || pending || (mem_req_m && !mem_ready_m);
        check("fwd_a", forward_a_e, fwd_src(rs1_e));
        check("fwd_b", forward_b_e, fwd_src(rs2_e));
        check("stall_fd", {stall_f, stall_d}, {2{frz | lw}});
        check("stall_em", {stall_e, stall_m}, {2{frz}});
        check("flush_d", flush_d, !frz && pc_src_e);
        check("flush_e", flush_e, !frz && (lw || pc_src_e));
        check("flush_w", flush_w, frz);
        check("timeout_err", timeout_err, dead);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        if (cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if ((frz || lw) && m_stall < CNT_TOP) m_stall++;
            if (pc_src_e && !frz && m_flush < CNT_TOP) m_flush++;
        end
        if (!dead) begin
            if (pending) begin
                if (mem_ready_m) pending = 0;
                else if (elapsed == MAX_WAIT) begin
                    pending = 0;
                    dead = 1;
                end else elapsed++;
            end else if (mem_req_m && !mem_ready_m) begin
                pending = 1;
                elapsed = 1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        step();
    endtask

    initial begin
        clear_inputs();
        #2 rst_n = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        clear_inputs();
        step();

        // Forwarding priority: memory stage over writeback
        @(negedge clk);
        rs1_e = 5'd3; rd_m = 5'd3; reg_write_m = 1; rd_w = 5'd3; reg_write_w = 1;
        step();
        check("fwd_a_mem", forward_a_e, 2'b10);
        @(negedge clk);
        rd_m = 5'd0;
        step();
        check("fwd_a_wb", forward_a_e, 2'b01);

        // Load-use stall, then a load into x0
        @(negedge clk);
        clear_inputs();
        result_src_e = 2'b01; rd_e = 5'd5; rs2_d = 5'd5;
        step();
        check("lw_stall", {stall_f, stall_d, flush_e}, 3'b111);
        @(negedge clk);
        rd_e = 5'd0; rs2_d = 5'd0; rs1_d = 5'd0;
        step();
        check("lw_x0", stall_f, 1'b0);

        // Branch redirect
        @(negedge clk);
        clear_inputs();
        pc_src_e = 1;
        step();
        check("br_flush", {flush_d, flush_e}, 2'b11);

        // Three not-ready cycles then ready: four frozen cycles with a pending redirect
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_req_m = 1; mem_ready_m = (i == 3); pc_src_e = 1;
            step();
            check("frz_hold", {stall_e, flush_e}, 2'b10);
        end
        @(negedge clk);
        mem_req_m = 0; mem_ready_m = 0;
        step();
        check("frz_release", {stall_e, flush_e}, 2'b01);

        // Memory never answers: timeout and sticky error, cleared by reset
        @(negedge clk);
        clear_inputs();
        mem_req_m = 1;
        step();
        for (int i = 0; i < MAX_WAIT + 3; i++) cycle();
        check("tmo_set", timeout_err, 1'b1);
        @(negedge clk);
        mem_req_m = 0;
        step();
        check("tmo_sticky", timeout_err, 1'b1);
        @(negedge clk);
        rst_n = 0;
        step();
        @(negedge clk);
        rst_n = 1;
        step();
        check("tmo_cleared", {timeout_err, stall_e}, 2'b00);

        // Counter saturation and clear-with-stall
        @(negedge clk);
        result_src_e = 2'b01; rd_e = 5'd7; rs1_d = 5'd7;
        step();
        for (int i = 0; i < CNT_TOP + 4; i++) cycle();
        check("sat_max", stall_cnt, 4'd15);
        @(negedge clk);
        cnt_clr = 1;
        step();
        @(negedge clk);
        cnt_clr = 0;
        step();
        check("clr_wins", stall_cnt, 4'd0);

        // Random traffic with occasional resets, more likely once timed out
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n        = dead ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 199) != 0);
            rs1_d        = 5'($urandom_range(0, 3));
            rs2_d        = 5'($urandom_range(0, 3));
            rs1_e        = 5'($urandom_range(0, 3));
            rs2_e        = 5'($urandom_range(0, 3));
            rd_e         = 5'($urandom_range(0, 3));
            rd_m         = 5'($urandom_range(0, 3));
            rd_w         = 5'($urandom_range(0, 3));
            result_src_e = 2'($urandom);
            reg_write_m  = 1'($urandom);
            reg_write_w  = 1'($urandom);
            pc_src_e     = ($urandom_range(0, 3) == 0);
            mem_req_m    = ($urandom_range(0, 2) == 0);
            mem_ready_m  = ($urandom_range(0, 2) != 0);
            cnt_clr      = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
